// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_port_arbiter                                             |
// | Description : Round-robin arbiter and access sequencer sharing one         |
// |               single-ported synchronous memory between instruction fetch   |
// |               (0), load/store datapath (1) and debug/loader port (2).      |
// |               Optional macro MEM_ARB_DBG_LOCK_EN adds dbg_lock, which      |
// |               restricts arbitration to requester 2 while asserted.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          req,
  input  logic [2:0]          we,
  input  logic [3*ADDR_W-1:0] addr,
  input  logic [3*DATA_W-1:0] wdata,
`ifdef MEM_ARB_DBG_LOCK_EN
  input  logic                dbg_lock,
`endif
  output logic [2:0]          ack,
  output logic [1:0]          gnt_id,
  output logic [DATA_W-1:0]   rdata,
  output logic                busy,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  // The wait-state down-counter is 4 bits wide, so latency is bounded.
  generate
    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
      $error("mem_port_arbiter: WAIT_CYCLES must be in 1..15");
    end
  endgenerate

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_access = 2'd1;
  localparam logic [1:0] c_st_wait   = 2'd2;
  localparam logic [1:0] c_st_done   = 2'd3;

  logic [1:0] r_state;
  logic [3:0] r_cnt;
  logic       r_we;
  logic [1:0] r_last;

  logic [2:0] w_elig;
  logic [1:0] w_ord0;
  logic [1:0] w_ord1;
  logic [1:0] w_ord2;
  logic [1:0] w_win;
  logic       w_found;

  // Search order starts just after the last winner and ends on it.
  assign w_ord0 = (r_last == 2'd2) ? 2'd0 : r_last + 2'd1;
  assign w_ord1 = (w_ord0 == 2'd2) ? 2'd0 : w_ord0 + 2'd1;
  assign w_ord2 = r_last;

  // Eligibility mask and rotating-priority winner selection.
  always_comb begin
    w_elig = req;
`ifdef MEM_ARB_DBG_LOCK_EN
    if (dbg_lock) begin
      w_elig = req & 3'b100;
    end
`endif
    w_found = 1'b1;
    w_win   = w_ord0;
    if (w_elig[w_ord0]) begin
      w_win = w_ord0;
    end else if (w_elig[w_ord1]) begin
      w_win = w_ord1;
    end else if (w_elig[w_ord2]) begin
      w_win = w_ord2;
    end else begin
      w_found = 1'b0;
    end
  end

  // Access sequencer: grant, one strobe cycle, wait states, one-cycle ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= c_st_idle;
      r_cnt     <= 4'd0;
      r_we      <= 1'b0;
      r_last    <= 2'd2;
      ack       <= 3'b000;
      gnt_id    <= 2'd0;
      rdata     <= '0;
      busy      <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      ack <= 3'b000;
      case (r_state)
        c_st_idle: begin
          if (w_found) begin
            gnt_id    <= w_win;
            busy      <= 1'b1;
            r_we      <= we[w_win];
            mem_en    <= 1'b1;
            mem_we    <= we[w_win];
            mem_addr  <= addr[w_win*ADDR_W +: ADDR_W];
            mem_wdata <= wdata[w_win*DATA_W +: DATA_W];
            r_state   <= c_st_access;
          end
        end
        c_st_access: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          if (WAIT_CYCLES > 1) begin
            r_cnt   <= 4'(WAIT_CYCLES - 1);
            r_state <= c_st_wait;
          end else begin
            ack <= 3'b001 << gnt_id;
            if (!r_we) begin
              rdata <= mem_rdata;
            end
            r_state <= c_st_done;
          end
        end
        c_st_wait: begin
          if (r_cnt == 4'd1) begin
            ack <= 3'b001 << gnt_id;
            if (!r_we) begin
              rdata <= mem_rdata;
            end
            r_state <= c_st_done;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        c_st_done: begin
          busy    <= 1'b0;
          r_last  <= gnt_id;
          r_state <= c_st_idle;
        end
        default: begin
          r_state <= c_st_idle;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Round-robin arbiter and access sequencer that shares one single-ported synchronous memory between three requesters: 0 = instruction fetch, 1 = load/store datapath, 2 = debug/loader port.
- Sits between the MIPS core (plus the external loader) and the unified memory array.
- Latches each granted request, drives the memory for a fixed number of wait states, then returns read data with a one-cycle acknowledge.

Parameters:
ADDR_W, 32, address width per requester and to memory
DATA_W, 32, data width
WAIT_CYCLES, 1, memory read latency in cycles after the mem_en cycle; legal range 1..15, elaboration error outside it

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
req  input  3  request per requester, bit i = requester i
we  input  3  write enable per requester, sampled at grant
addr  input  3*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
wdata  input  3*DATA_W  packed write data; requester i at [i*DATA_W +: DATA_W]
ack  output  3  one-cycle completion pulse per requester
gnt_id  output  2  index of the requester being served; valid while busy=1 or any ack bit=1
rdata  output  DATA_W  read data for the acked read; held until the next read completes
busy  output  1  high from grant until the end of the DONE cycle
mem_en  output  1  memory access strobe
mem_we  output  1  memory write strobe
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data, valid WAIT_CYCLES cycles after the mem_en cycle

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; ack=0, gnt_id=0, rdata=0, busy=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0; last-grant pointer=2, so requester 0 has first priority.
- An in-flight access is aborted by reset. No ack is issued for it.
- States:
  - IDLE: if any eligible req bit is set at the clock edge, select the winner, latch we/addr/wdata, set gnt_id and busy, and go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: exactly one cycle with mem_en=1, mem_we=latched we, mem_addr/mem_wdata=latched values. Go to WAIT if WAIT_CYCLES>1, else go to DONE.
  - WAIT: lasts WAIT_CYCLES-1 cycles, counted by a 4-bit down-counter. mem_en=0. Go to DONE when the counter expires.
  - DONE: one cycle. ack[gnt_id]=1. rdata was loaded from mem_rdata on the entering edge, for reads only; writes leave rdata unchanged. Update the pointer to gnt_id, then go to IDLE.
- Transaction period = WAIT_CYCLES+2 cycles. Latency from the sampling edge to the ack-high cycle = WAIT_CYCLES+1 cycles.
- Arbitration: search order (last+1) mod 3, (last+2) mod 3, last. This is strict rotation; with all three requests asserted, grants go 0,1,2,0,...
- Request lifetime: req may drop before it is granted with no effect. Once granted, the transaction completes from latched values even if req drops. A req still high after its ack is treated as a new request.
- busy=1 in ACCESS, WAIT and DONE.
- Address wrap and range checking belong to the memory, not this block.

Optional Feature:
MEM_ARB_DBG_LOCK_EN
- Defined: adds an input port dbg_lock (1 bit). While dbg_lock=1 at an IDLE sampling edge, only requester 2 is eligible. Requesters 0 and 1 stall with no ack. A transaction already granted completes normally. The rotation pointer still updates on every grant.
- Undefined: the dbg_lock port is absent and arbitration is pure round-robin.

Test Plan:
1. WAIT_CYCLES=1; req=001, addr0=0x10, mem_rdata=0xDEADBEEF -> mem_en high for exactly one cycle with mem_addr=0x10 and mem_we=0; ack=001 two cycles after the sampling edge; rdata=0xDEADBEEF; gnt_id=0.
2. WAIT_CYCLES=1; req=111 held -> acks in order 001, 010, 100, 001, spaced 3 cycles apart; mem_addr follows addr0, addr1, addr2.
3. Write: req=010, we=010, addr1=0x20, wdata1=0x00001234 -> mem_we=1, mem_wdata=0x00001234 in the ACCESS cycle; ack=010; rdata keeps its prior value.
4. WAIT_CYCLES=4; req=100 -> ACCESS, then 3 WAIT cycles with mem_en=0, then ack=100 five cycles after the sampling edge.
5. Reset pulse during WAIT -> mem_en, ack and busy go 0 asynchronously; no ack after release; with req=111 afterwards, requester 0 is granted first.
6. MEM_ARB_DBG_LOCK_EN defined; dbg_lock=1, req=111 -> only ack=100, repeatedly. Lower dbg_lock -> next grants go to 0, then 1.
